// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU, comparator and
// multiplier opcodes plus the multiplier FSM state encoding.
package ex_pkg;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_e;

   typedef enum logic [2:0] {
      CMP_EQ  = 3'd0,
      CMP_NE  = 3'd1,
      CMP_LT  = 3'd4,
      CMP_GE  = 3'd5,
      CMP_LTU = 3'd6,
      CMP_GEU = 3'd7
   } comp_op_e;

   typedef enum logic [1:0] {
      MUL_MUL    = 2'd0,
      MUL_MULH   = 2'd1,
      MUL_MULHSU = 2'd2,
      MUL_MULHU  = 2'd3
   } mul_op_e;

   typedef enum logic [1:0] {
      MS_IDLE = 2'd0,
      MS_MUL  = 2'd1,
      MS_DONE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative radix-2 shift-add multiplier: one multiplier bit per cycle,
// magnitudes multiplied unsigned and the sign restored in DONE.
module ex_mul_iter
   import ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_i,
   input  logic            start_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic [1:0]      op_i,
   input  logic            ack_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] res_o
);

   localparam int CW = $clog2(XLEN + 1);

   mul_state_e        state_q, state_d;
   logic [2*XLEN-1:0] prod_q, prod_d;
   logic [XLEN-1:0]   mcand_q, mcand_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              neg_q, neg_d;
   logic              hi_q, hi_d;

   logic              a_sgn, b_sgn;
   logic [XLEN-1:0]   a_abs, b_abs;
   logic [XLEN:0]     sum;
   logic [2*XLEN-1:0] fin;

   always_comb begin
      a_sgn = (op_i == MUL_MULH || op_i == MUL_MULHSU) && a_i[XLEN-1];
      b_sgn = (op_i == MUL_MULH) && b_i[XLEN-1];
      a_abs = a_sgn ? -a_i : a_i;
      b_abs = b_sgn ? -b_i : b_i;
      // Low half of prod_q doubles as the shifting multiplier.
      sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};

      state_d = state_q;
      prod_d  = prod_q;
      mcand_d = mcand_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      hi_d    = hi_q;

      unique case (state_q)
         MS_IDLE: begin
            if (start_i) begin
               state_d = MS_MUL;
               prod_d  = {{XLEN{1'b0}}, b_abs};
               mcand_d = a_abs;
               cnt_d   = '0;
               neg_d   = a_sgn ^ b_sgn;
               hi_d    = (op_i != MUL_MUL);
            end
         end
         MS_MUL: begin
            if (prod_q[0]) prod_d = {sum, prod_q[XLEN-1:1]};
            else           prod_d = {1'b0, prod_q[2*XLEN-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN - 1)) state_d = MS_DONE;
         end
         MS_DONE: begin
            if (ack_i) state_d = MS_IDLE;
         end
         default: state_d = MS_IDLE;
      endcase

      if (flush_i) state_d = MS_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MS_IDLE;
         prod_q  <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         hi_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         prod_q  <= prod_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
      end
   end

   assign fin    = neg_q ? -prod_q : prod_q;
   assign res_o  = hi_q ? fin[2*XLEN-1:XLEN] : fin[XLEN-1:0];
   assign done_o = (state_q == MS_DONE);
   assign busy_o = (state_q != MS_IDLE);

endmodule

// File: rtl/ex_stage_fwd.sv
// Execute stage with MEM/WB forwarding, ALU, comparator, iterative
// multiplier and the EX/MEM register behind a valid/ready handshake.
module ex_stage_fwd
   import ex_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int MUL_EN = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_a,
   input  logic [XLEN-1:0]   in_b,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [REG_AW-1:0] in_rs1,
   input  logic [REG_AW-1:0] in_rs2,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              b_imm_sel,
   input  logic              a_pc_sel,
   input  logic [3:0]        alu_op,
   input  logic [2:0]        comp_op,
   input  logic              mul_en,
   input  logic [1:0]        mul_op,
   input  logic              fwd_mem_vld,
   input  logic              fwd_wb_vld,
   input  logic [REG_AW-1:0] fwd_mem_rd,
   input  logic [REG_AW-1:0] fwd_wb_rd,
   input  logic [XLEN-1:0]   fwd_mem_data,
   input  logic [XLEN-1:0]   fwd_wb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_alu,
   output logic              out_comp,
   output logic [XLEN-1:0]   out_b,
   output logic [XLEN-1:0]   out_pc,
   output logic [REG_AW-1:0] out_rd,
   output logic              busy
);

   localparam int SW = $clog2(XLEN);

   function automatic logic [XLEN-1:0] fwd_sel(
      input logic [REG_AW-1:0] rs,
      input logic [XLEN-1:0]   raw
   );
      if (rs != '0 && fwd_mem_vld && fwd_mem_rd == rs) return fwd_mem_data;
      if (rs != '0 && fwd_wb_vld && fwd_wb_rd == rs)   return fwd_wb_data;
      return raw;
   endfunction

   logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b;
   logic [SW-1:0]   shamt;
   logic [XLEN-1:0] alu_res;
   logic            cmp_res;

   assign fwd_a = fwd_sel(in_rs1, in_a);
   assign fwd_b = fwd_sel(in_rs2, in_b);
   assign op_a  = a_pc_sel ? in_pc : fwd_a;
   assign op_b  = b_imm_sel ? in_imm : fwd_b;
   assign shamt = op_b[SW-1:0];

   always_comb begin
      alu_res = '0;
      case (alu_op)
         ALU_ADD:   alu_res = op_a + op_b;
         ALU_SUB:   alu_res = op_a - op_b;
         ALU_SLL:   alu_res = op_a << shamt;
         ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
         ALU_XOR:   alu_res = op_a ^ op_b;
         ALU_SRL:   alu_res = op_a >> shamt;
         ALU_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
         ALU_OR:    alu_res = op_a | op_b;
         ALU_AND:   alu_res = op_a & op_b;
         ALU_PASSB: alu_res = op_b;
         default:   alu_res = '0;
      endcase
   end

   always_comb begin
      cmp_res = 1'b0;
      case (comp_op)
         CMP_EQ:  cmp_res = (op_a == op_b);
         CMP_NE:  cmp_res = (op_a != op_b);
         CMP_LT:  cmp_res = ($signed(op_a) < $signed(op_b));
         CMP_GE:  cmp_res = ($signed(op_a) >= $signed(op_b));
         CMP_LTU: cmp_res = (op_a < op_b);
         CMP_GEU: cmp_res = (op_a >= op_b);
         default: cmp_res = 1'b0;
      endcase
   end

   logic            is_mul, accept, reg_free;
   logic            mul_start, alu_load, mul_load;
   logic            mul_busy, mul_done;
   logic [XLEN-1:0] mul_res;

   assign is_mul    = (MUL_EN != 0) && mul_en;
   assign reg_free  = !out_valid || out_ready;
   assign in_ready  = !mul_busy && reg_free;
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && is_mul && !flush;
   assign alu_load  = accept && !is_mul && !flush;
   assign mul_load  = mul_done && reg_free && !flush;
   assign busy      = mul_busy;

   ex_mul_iter #(.XLEN(XLEN)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .start_i (mul_start),
      .a_i     (op_a),
      .b_i     (op_b),
      .op_i    (mul_op),
      .ack_i   (mul_load),
      .busy_o  (mul_busy),
      .done_o  (mul_done),
      .res_o   (mul_res)
   );

   // Pass-through fields of an in-flight multiply.
   logic [XLEN-1:0]   mpc_q, mb_q;
   logic [REG_AW-1:0] mrd_q;

   logic              vld_q, vld_d;
   logic [XLEN-1:0]   alu_q, alu_d, b_q, b_d, pc_q, pc_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic              comp_q, comp_d;

   always_comb begin
      vld_d  = vld_q;
      alu_d  = alu_q;
      b_d    = b_q;
      pc_d   = pc_q;
      rd_d   = rd_q;
      comp_d = comp_q;
      if (out_ready) vld_d = 1'b0;
      if (alu_load) begin
         vld_d  = 1'b1;
         alu_d  = alu_res;
         comp_d = cmp_res;
         b_d    = fwd_b;
         pc_d   = in_pc;
         rd_d   = in_rd;
      end else if (mul_load) begin
         vld_d  = 1'b1;
         alu_d  = mul_res;
         comp_d = 1'b0;
         b_d    = mb_q;
         pc_d   = mpc_q;
         rd_d   = mrd_q;
      end
      if (flush) vld_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         alu_q  <= '0;
         b_q    <= '0;
         pc_q   <= '0;
         rd_q   <= '0;
         comp_q <= 1'b0;
         mpc_q  <= '0;
         mb_q   <= '0;
         mrd_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         alu_q  <= alu_d;
         b_q    <= b_d;
         pc_q   <= pc_d;
         rd_q   <= rd_d;
         comp_q <= comp_d;
         if (mul_start) begin
            mpc_q <= in_pc;
            mb_q  <= fwd_b;
            mrd_q <= in_rd;
         end
      end
   end

   assign out_valid = vld_q;
   assign out_alu   = alu_q;
   assign out_comp  = comp_q;
   assign out_b     = b_q;
   assign out_pc    = pc_q;
   assign out_rd    = rd_q;

endmodule

// File: tb/tb_ex_stage_fwd.sv
// Directed and randomized checks of ex_stage_fwd against an
// arithmetic reference model (XLEN = 32).
module tb_ex_stage_fwd;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] in_pc, in_a, in_b, in_imm;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic        b_imm_sel, a_pc_sel;
   logic [3:0]  alu_op;
   logic [2:0]  comp_op;
   logic        mul_en;
   logic [1:0]  mul_op;
   logic        fwd_mem_vld, fwd_wb_vld;
   logic [4:0]  fwd_mem_rd, fwd_wb_rd;
   logic [31:0] fwd_mem_data, fwd_wb_data;
   logic        flush;
   logic        out_valid, out_ready;
   logic [31:0] out_alu, out_b, out_pc;
   logic        out_comp;
   logic [4:0]  out_rd;
   logic        busy;

   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   ex_stage_fwd #(.XLEN(32), .REG_AW(5), .MUL_EN(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .b_imm_sel(b_imm_sel), .a_pc_sel(a_pc_sel),
      .alu_op(alu_op), .comp_op(comp_op),
      .mul_en(mul_en), .mul_op(mul_op),
      .fwd_mem_vld(fwd_mem_vld), .fwd_wb_vld(fwd_wb_vld),
      .fwd_mem_rd(fwd_mem_rd), .fwd_wb_rd(fwd_wb_rd),
      .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_alu(out_alu), .out_comp(out_comp), .out_b(out_b),
      .out_pc(out_pc), .out_rd(out_rd), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] raw);
      if (rs != 0 && fwd_mem_vld && fwd_mem_rd == rs) return fwd_mem_data;
      if (rs != 0 && fwd_wb_vld && fwd_wb_rd == rs) return fwd_wb_data;
      return raw;
   endfunction

   function automatic logic [31:0] m_opa();
      return a_pc_sel ? in_pc : m_fwd(in_rs1, in_a);
   endfunction

   function automatic logic [31:0] m_opb();
      return b_imm_sel ? in_imm : m_fwd(in_rs2, in_b);
   endfunction

   function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      int sh;
      sa = a;
      sh = int'(b % 32);
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a << sh;
         4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd4:  return (a < b) ? 32'd1 : 32'd0;
         4'd5:  return a ^ b;
         4'd6:  return a >> sh;
         4'd7:  return sa >>> sh;
         4'd8:  return a | b;
         4'd9:  return a & b;
         4'd10: return b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic m_cmp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] m_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
      eb = (op == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
      p  = ea * eb;
      return (op == 2'd0) ? p[31:0] : p[63:32];
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic clear_inputs();
      in_valid = 0; in_pc = 0; in_a = 0; in_b = 0; in_imm = 0;
      in_rs1 = 0; in_rs2 = 0; in_rd = 0; b_imm_sel = 0; a_pc_sel = 0;
      alu_op = 0; comp_op = 0; mul_en = 0; mul_op = 0;
      fwd_mem_vld = 0; fwd_wb_vld = 0; fwd_mem_rd = 0; fwd_wb_rd = 0;
      fwd_mem_data = 0; fwd_wb_data = 0; flush = 0;
   endtask

   task automatic do_accept(input string tag);
      int w;
      w = 0;
      in_valid = 1;
      while (!in_ready && w < 100) begin
         @(posedge clk); #1; w++;
      end
      chk({tag, "_acc_to"}, 64'(w < 100), 64'd1);
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic rand_op();
      in_pc  = $urandom; in_a = $urandom; in_b = $urandom; in_imm = $urandom;
      in_rs1 = 5'($urandom_range(3, 0));
      in_rs2 = 5'($urandom_range(3, 0));
      in_rd  = 5'($urandom);
      b_imm_sel = 1'($urandom); a_pc_sel = 1'($urandom);
      fwd_mem_vld = 1'($urandom); fwd_wb_vld = 1'($urandom);
      fwd_mem_rd = 5'($urandom_range(3, 0));
      fwd_wb_rd  = 5'($urandom_range(3, 0));
      fwd_mem_data = $urandom; fwd_wb_data = $urandom;
   endtask

   // Issues a multiply and checks latency, busy/in_ready and the result.
   task automatic run_mul(input string tag);
      logic [31:0] e_res, e_b, e_pc;
      logic [4:0]  e_rd;
      int cyc, bad;
      mul_en = 1;
      e_res = m_mul(mul_op, m_opa(), m_opb());
      e_b = m_fwd(in_rs2, in_b); e_pc = in_pc; e_rd = in_rd;
      do_accept(tag);
      rand_op();
      cyc = 1; bad = 0;
      while (!out_valid && cyc < 100) begin
         if (!busy || in_ready) bad++;
         @(posedge clk); #1; cyc++;
      end
      mul_en = 0;
      chk({tag, "_lat"}, 64'(cyc), 64'd34);
      chk({tag, "_busy"}, 64'(bad), 64'd0);
      chk({tag, "_res"}, 64'(out_alu), 64'(e_res));
      chk({tag, "_b"}, 64'(out_b), 64'(e_b));
      chk({tag, "_pc_rd"}, {out_pc, 27'd0, out_rd}, {e_pc, 27'd0, e_rd});
      @(posedge clk); #1;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [31:0] e1, e2;
      int cnt;
      clear_inputs();
      out_ready = 1;
      rst_n = 0;
      #12;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_alu", 64'(out_alu), 64'd0);
      chk("rst_inready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;

      // ADD with immediate wrap
      in_a = 32'd5; in_imm = 32'hFFFF_FFFF; b_imm_sel = 1; alu_op = 0;
      in_pc = 32'h100; in_rd = 5'd7;
      do_accept("add");
      chk("add_valid", 64'(out_valid), 64'd1);
      chk("add_res", 64'(out_alu), 64'd4);
      chk("add_rd", 64'(out_rd), 64'd7);
      @(posedge clk); #1;
      chk("drain_valid", 64'(out_valid), 64'd0);

      // Forwarding priority and x0 exclusion
      clear_inputs();
      in_rs1 = 5'd3; in_a = 32'h100; b_imm_sel = 1; in_imm = 32'd1;
      fwd_mem_vld = 1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'h10;
      fwd_wb_vld = 1; fwd_wb_rd = 5'd3; fwd_wb_data = 32'h20;
      do_accept("fwd");
      chk("fwd_mem", 64'(out_alu), 64'h11);
      fwd_mem_vld = 0;
      do_accept("fwdwb");
      chk("fwd_wb", 64'(out_alu), 64'h21);
      in_rs1 = 5'd0; fwd_mem_vld = 1; fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0;
      do_accept("fwd0");
      chk("fwd_x0", 64'(out_alu), 64'h101);

      // Randomized ALU/comparator ops
      for (int i = 0; i < 40; i++) begin
         rand_op();
         alu_op = 4'($urandom); comp_op = 3'($urandom);
         e1 = m_alu(alu_op, m_opa(), m_opb());
         e2 = m_fwd(in_rs2, in_b);
         cnt = int'(m_cmp(comp_op, m_opa(), m_opb()));
         do_accept("rnd");
         chk($sformatf("rnd_alu%0d_op%0d", i, alu_op), 64'(out_alu), 64'(e1));
         chk($sformatf("rnd_cmp%0d_op%0d", i, comp_op), 64'(out_comp), 64'(cnt));
         chk($sformatf("rnd_b%0d", i), 64'(out_b), 64'(e2));
      end
      @(posedge clk); #1;

      // Directed multiplies
      clear_inputs();
      in_a = 32'hFFFF_FFFE; in_b = 32'd3; mul_op = 2'd1; in_rd = 5'd9;
      run_mul("mulh");
      clear_inputs();
      in_a = 32'hFFFF_FFFE; in_b = 32'd3; mul_op = 2'd3;
      run_mul("mulhu");
      for (int i = 0; i < 6; i++) begin
         clear_inputs();
         rand_op();
         mul_op = 2'(i);
         if (i == 5) begin a_pc_sel = 0; b_imm_sel = 0; in_rs1 = 0; in_rs2 = 0; in_a = 32'h8000_0000; in_b = 32'hFFFF_FFFF; mul_op = 2'd2; end
         run_mul($sformatf("mulr%0d", i));
      end

      // Backpressure
      clear_inputs();
      out_ready = 0;
      in_a = 32'd10; in_b = 32'd3; alu_op = 4'd1; in_pc = 32'h40; in_rd = 5'd2;
      do_accept("bp1");
      in_a = 32'hF0; in_b = 32'h0F; alu_op = 4'd8; in_rd = 5'd4;
      e2 = m_alu(alu_op, m_opa(), m_opb());
      in_valid = 1;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (!out_valid || out_alu !== 32'd7 || out_rd !== 5'd2 || out_pc !== 32'h40 || in_ready) cnt++;
      end
      chk("bp_hold", 64'(cnt), 64'd0);
      out_ready = 1;
      #1;
      chk("bp_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 0;
      chk("bp_next_v", 64'(out_valid), 64'd1);
      chk("bp_next", 64'(out_alu), 64'(e2));
      @(posedge clk); #1;

      // Flush mid-multiply
      clear_inputs();
      in_a = 32'd123; in_b = 32'd456; mul_en = 1;
      do_accept("flm");
      mul_en = 0;
      repeat (9) begin @(posedge clk); #1; end
      flush = 1;
      @(posedge clk); #1;
      flush = 0;
      chk("fl_busy", 64'(busy), 64'd0);
      cnt = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) cnt++;
      end
      chk("fl_novalid", 64'(cnt), 64'd0);
      // Flush discards a same-cycle accept
      in_a = 32'd1; in_b = 32'd2; in_valid = 1; flush = 1;
      @(posedge clk); #1;
      in_valid = 0; flush = 0;
      chk("fl_acc", 64'(out_valid), 64'd0);
      do_accept("fladd");
      chk("fl_add", 64'(out_alu), 64'd3);
      @(posedge clk); #1;

      // Async reset mid-multiply
      in_a = 32'd7; in_b = 32'd9; mul_en = 1; in_pc = 32'h55; in_rd = 5'd3;
      do_accept("rstm");
      mul_en = 0;
      repeat (5) begin @(posedge clk); #1; end
      rst_n = 0;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_out", {out_alu, out_pc}, 64'd0);
      chk("arst_misc", {out_b, 24'd0, out_valid, out_comp, out_rd}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
      clear_inputs();
      in_a = 32'h8000_0000; in_imm = 32'd4; b_imm_sel = 1; alu_op = 4'd7;
      do_accept("sra");
      chk("sra", 64'(out_alu), 64'hF800_0000);
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/ex_stage_fwd.md
Name: ex_stage_fwd

Overview:
Parametrised execute stage for the RISC-V pipeline, successor to the single-cycle EX block. It adds operand forwarding from the MEM and WB stages and a registered output with valid/ready handshake. It also adds flush, and an iterative multi-cycle multiplier for MUL/MULH/MULHSU/MULHU. It sits between the ID/EX register and the MEM stage and owns the EX/MEM pipeline register.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
REG_AW, 5, register index width
MUL_EN, 1, 1 = iterative multiplier present; 0 = mul_en ignored and treated as ALU op

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  upstream operation valid
in_ready  out  1  stage can accept an operation
in_pc, in_a, in_b, in_imm  in  XLEN  PC, rs1 value, rs2 value, immediate
in_rs1, in_rs2, in_rd  in  REG_AW  source and destination indices
b_imm_sel  in  1  1 = operand B is in_imm
a_pc_sel  in  1  1 = operand A is in_pc
alu_op  in  4  ALU function
comp_op  in  3  comparator function
mul_en  in  1  operation is a multiply
mul_op  in  2  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
fwd_mem_vld, fwd_wb_vld  in  1  forwarding source writes a register
fwd_mem_rd, fwd_wb_rd  in  REG_AW  forwarding destination index
fwd_mem_data, fwd_wb_data  in  XLEN  forwarding data
flush  in  1  kill in-flight and registered operation
out_valid  out  1  EX/MEM register holds a valid result
out_ready  in  1  downstream accepts the result
out_alu  out  XLEN  ALU or multiply result
out_comp  out  1  comparator result
out_b  out  XLEN  forwarded rs2 value (store data)
out_pc  out  XLEN  PC passed through
out_rd  out  REG_AW  destination passed through
busy  out  1  multiplier FSM is not IDLE

Behaviour:
- Reset (rst_n low, asynchronous): every out_* = 0, out_valid = 0, busy = 0, FSM = IDLE.
- Forwarding, combinational, per source index: if fwd_mem_vld and fwd_mem_rd == rsN and rsN != 0, use fwd_mem_data. Else if the WB source matches under the same rule, use fwd_wb_data. Else use in_a/in_b. MEM has priority over WB. Index 0 is never forwarded.
- Operand A = a_pc_sel ? in_pc : fwd A. Operand B = b_imm_sel ? in_imm : fwd B. out_b always takes fwd B.
- ALU ops (width XLEN, result wraps mod 2^XLEN): 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB. Codes 11–15 produce 0.
- Shift amount = operand B[log2(XLEN)-1:0].
- Comparator ops: 0 EQ, 1 NE, 4 LT, 5 GE, 6 LTU, 7 GEU. Codes 2 and 3 produce 0.
- Handshake: in_ready = !busy && (!out_valid || out_ready). An operation is accepted when in_valid && in_ready.
- Result drain: out_valid clears on out_ready unless a new result is loaded in the same cycle.
- Single-cycle op: the EX/MEM register is loaded on the accept edge, so out_valid rises 1 cycle after accept.
- Multiply op, FSM IDLE -> MUL -> DONE -> IDLE:
  - Accept captures |A|, |B|, the sign flags, rd, pc and fwd B. The sign flags per mul_op are MULH both signed, MULHSU A signed only, MUL/MULHU unsigned.
  - MUL state: radix-2 shift-add, one bit per cycle, XLEN cycles, over a 2*XLEN accumulator.
  - DONE state: conditionally negate the product. Load the low half for MUL, the high half otherwise. Set out_valid. Return to IDLE.
  - Accept-to-out_valid latency = XLEN+2 cycles. busy = 1 in MUL and DONE.
- Output stall: the EX/MEM register holds every field while out_valid && !out_ready. A DONE result waits in DONE until the register is free; busy stays high.
- Flush: synchronous, highest priority. Next edge gives out_valid = 0 and FSM = IDLE; any accept in that cycle is discarded. Data fields may keep stale values.
- Reset mid-multiply returns the FSM to IDLE immediately; no result is produced.
- in_ready is low while busy, so no back-to-back multiplies overlap.

Decomposition:
- Package ex_pkg holds the alu_op_e, comp_op_e, mul_op_e and mul_state_e enums and the ALU/comparator code constants.
- One sub-module, ex_mul_iter, contains the FSM, accumulator, sign handling and a start/done interface. The top level holds the forwarding, the muxes, the combinational ALU/comparator and the EX/MEM register.

Test Plan:
1. ADD, A=5, B=imm=0xFFFFFFFF (b_imm_sel=1) -> out_alu=0x4 and out_valid=1 one cycle after accept.
2. Forwarding: in_rs1=3, fwd_mem_rd=3 with data 0x10, fwd_wb_rd=3 with data 0x20, ADD with B=1 -> out_alu=0x11. Repeat with rs1=0 -> uses in_a.
3. MULH with A=0xFFFFFFFE (-2), B=3 -> out_alu=0xFFFFFFFF, out_valid at accept+34 (XLEN=32), busy high throughout, in_ready=0. MULHU same operands -> 0x2.
4. Backpressure: out_ready=0 with out_valid=1 -> fields stable, in_ready=0. Release -> next op accepted in the same cycle.
5. Flush at multiply cycle 10 -> busy drops the next cycle, out_valid never rises. A following ADD completes normally.
6. rst_n low mid-multiply -> all outputs 0 asynchronously. After release, SRA 0x80000000 by 4 -> 0xF8000000.
